// File: rtl/cgra_conf_writer.sv
// Purpose: turns a header+data word stream into addressed 64-bit configuration beats for the PE array.
// Latency: 1 cycle from an accepted data word to its beat on conf_bus_out; done/err/busy are registered.
// Backpressure: none; s_ready is always 1 and a low s_valid simply stalls the packet in place.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   s_valid/s_data     input word stream (header word, then `count` data words)
//   s_ready            always high
//   clear_err          clears the sticky err flag (a simultaneous illegal header wins)
//   conf_bus_out       {valid, pe_id, cmd, thread_id, addr, 13'b0, data}; all zero when no beat
//   busy               packet in progress (DATA or SKIP)
//   done               one-cycle pulse when a packet completes
//   err                sticky illegal-header flag
//   beat_count         number of beats emitted since reset (wraps)
module cgra_conf_writer #(
    parameter int unsigned NUM_PE     = 128,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    input  logic [31:0] s_data,
    output logic        s_ready,
    input  logic        clear_err,
    output logic [63:0] conf_bus_out,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] beat_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        SKIP = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [6:0]              pe_q, pe_d;
    logic [3:0]              cmd_q, cmd_d;
    logic [2:0]              thr_q, thr_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [13:0]             rem_q, rem_d;
    logic [63:0]             bus_q, bus_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic [31:0]             cnt_q, cnt_d;

    // Header field views of the incoming word.
    logic [6:0]  hdr_pe;
    logic [3:0]  hdr_cmd;
    logic [2:0]  hdr_thr;
    logic [3:0]  hdr_addr;
    logic [13:0] hdr_count;
    logic        hdr_legal;
    logic        xfer;
    logic        err_set;
    logic [3:0]  addr_field;

    assign hdr_pe    = s_data[31:25];
    assign hdr_cmd   = s_data[24:21];
    assign hdr_thr   = s_data[20:18];
    assign hdr_addr  = s_data[17:14];
    assign hdr_count = s_data[13:0];
    assign hdr_legal = (hdr_cmd inside {[4'd1:4'd7]}) && (32'(hdr_pe) < NUM_PE);

    assign s_ready    = 1'b1;
    assign xfer       = s_valid & s_ready;
    assign addr_field = 4'(addr_q);

    always_comb begin
        state_d = state_q;
        pe_d    = pe_q;
        cmd_d   = cmd_q;
        thr_d   = thr_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        bus_d   = 64'd0;          // bus is zero in every cycle without a beat
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        err_set = 1'b0;

        case (state_q)
            IDLE: begin
                if (xfer) begin
                    rem_d = hdr_count;
                    if (hdr_legal) begin
                        pe_d   = hdr_pe;
                        cmd_d  = hdr_cmd;
                        thr_d  = hdr_thr;
                        addr_d = ADDR_WIDTH'(hdr_addr);
                        if (hdr_count != 14'd0) state_d = DATA;
                        else                    done_d  = 1'b1;
                    end else begin
                        err_set = 1'b1;
                        if (hdr_count != 14'd0) state_d = SKIP;
                        else                    done_d  = 1'b1;
                    end
                end
            end
            DATA: begin
                if (xfer) begin
                    bus_d  = {1'b1, pe_q, cmd_q, thr_q, addr_field, 13'd0, s_data};
                    cnt_d  = cnt_q + 32'd1;
                    addr_d = addr_q + ADDR_WIDTH'(1);
                    rem_d  = rem_q - 14'd1;
                    if (rem_q == 14'd1) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            SKIP: begin
                if (xfer) begin
                    rem_d = rem_q - 14'd1;
                    if (rem_q == 14'd1) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A new illegal header takes priority over a same-cycle clear.
        if (err_set)        err_d = 1'b1;
        else if (clear_err) err_d = 1'b0;
        else                err_d = err_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pe_q    <= '0;
            cmd_q   <= '0;
            thr_q   <= '0;
            addr_q  <= '0;
            rem_q   <= '0;
            bus_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pe_q    <= pe_d;
            cmd_q   <= cmd_d;
            thr_q   <= thr_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            bus_q   <= bus_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign conf_bus_out = bus_q;
    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign err          = err_q;
    assign beat_count   = cnt_q;

endmodule
